ysyx_22051110_cache_flush_seq: RTL and testbench
================================================

# ysyx_22051110_cache_flush_seq

Cache maintenance sequencer that drives the D-cache metadata RAM from the controller side. On a fence request it walks all 64 sets, reads each set's valid/dirty/tag entry, and hands every valid-and-dirty line to the writeback unit. It then either clears the dirty bit (clean mode) or invalidates the whole RAM with one flush pulse (invalidate mode). The sequencer sits between the fence/CSR logic, the metadata RAM port, and the writeback unit. The cache top gives it the metadata RAM port while `busy` is high.

## Interface
Parameters: none. Geometry is fixed at 64 sets and a 23-bit tag.
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  fence request; sampled only in IDLE
- inv  in  1  mode, sampled with start: 1 = invalidate after writeback, 0 = clean only
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in the FIN state
- meta_en  out  1  metadata RAM enable
- meta_wr  out  1  metadata RAM write select
- meta_addr  out  6  set index
- meta_wvalid  out  1  write data, valid bit
- meta_wdirty  out  1  write data, dirty bit
- meta_wtag  out  23  write data, tag
- meta_flush  out  1  clears all valid/dirty bits in the metadata RAM
- meta_valid  in  1  read data, valid bit; registered, valid the cycle after a read enable
- meta_dirty  in  1  read data, dirty bit; same timing as meta_valid
- meta_tag  in  23  read data, tag; same timing as meta_valid
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback unit accepts the request
- wb_tag  out  23  tag of the line to write back
- wb_index  out  6  set of the line to write back
- wb_done  in  1  one-cycle pulse: line data has been written to memory

## Operation
- State registers: state, idx[5:0], mode_inv, ltag[22:0].
- **IDLE**
  - If start=1: latch inv into mode_inv, set idx=0, go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - Drive meta_en=1, meta_wr=0, meta_addr=idx.
  - Go to CHECK.
- **CHECK**
  - Metadata for set idx is present on meta_valid/meta_dirty/meta_tag; copy meta_tag into ltag.
  - If meta_valid & meta_dirty: go to WB_REQ.
  - Otherwise advance.
- **WB_REQ**
  - Drive wb_valid=1, wb_tag=ltag, wb_index=idx; hold them stable until wb_ready=1.
  - On wb_valid & wb_ready: go to WB_WAIT.
- **WB_WAIT**
  - Wait for wb_done=1.
  - Then go to CLEAN if mode_inv=0; advance if mode_inv=1.
  - wb_done is ignored in every other state.
- **CLEAN**
  - Drive meta_en=1, meta_wr=1, meta_addr=idx, meta_wvalid=1, meta_wdirty=0, meta_wtag=ltag.
  - Then advance.
- **Advance** (not a state):
  - If idx==63: go to FIN.
  - Otherwise idx=idx+1 (6-bit, never wraps while active) and go to READ.
- **FIN**
  - done=1; meta_flush=mode_inv; go to IDLE.
- **Line selection**
  - Valid-but-clean lines and invalid lines are never written back.
  - A dirty-but-invalid entry is not written back.
- **Other inputs**
  - start is ignored while busy.
  - inv is ignored outside IDLE.

## Timing
- **Reset:** state=IDLE, idx=0, mode_inv=0, ltag=0. Every output is 0 the cycle after reset is asserted.
- **Reset mid-operation:** the walk is abandoned with no flush and no done. An outstanding writeback is dropped from the sequencer's view.
- **Outputs:** all are Moore (functions of state and registers only). No combinational path from any input to any output.
- **Metadata read latency:** 1 cycle (READ → CHECK).
- **Clean set:** costs 2 cycles.
- **Dirty set:** costs 2 + (WB_REQ cycles) + (WB_WAIT cycles) + (1 if clean mode).
- **All-clean walk:** start high at edge 0 → READ in cycle 1 → FIN (done=1) in cycle 129 → busy=0 from cycle 130.
- **FIN cycle:** done and meta_flush assert in the same cycle.
- **meta_en usage:** asserted only in READ and CLEAN, so the sequencer never reads and writes the RAM in the same cycle.
- **Start after FIN:** a start in the first IDLE cycle after FIN is accepted and begins a new walk.

## Test plan
- All 64 sets clean, inv=0, start at cycle 0:
  - Done pulses in cycle 129; busy falls in cycle 130.
  - wb_valid, meta_wr and meta_flush never assert.
- Set 5 holds valid=1, dirty=1, tag=0x12345; inv=0; wb_ready held 1; wb_done in the third WB_WAIT cycle:
  - Exactly one request with wb_index=5, wb_tag=0x12345, in cycle 13.
  - CLEAN write in cycle 17: addr=5, valid=1, dirty=0, tag=0x12345.
  - Done in cycle 134.
- Sets 0 and 63 dirty, inv=1:
  - Two writeback requests, index 0 then 63.
  - No CLEAN writes.
  - meta_flush=1 and done=1 in the same single cycle.
- Set 10 dirty, wb_ready held 0 for 10 cycles:
  - wb_valid stays high with wb_index=10 and wb_tag constant for all 11 cycles.
  - A wb_done pulse injected during WB_REQ is ignored.
- Reset asserted in WB_WAIT:
  - All outputs 0 the next cycle; no done or flush.
  - A new start walks again from set 0.
- Mixed case, start re-asserted in cycle 50 while busy:
  - Set 3 is valid=1, dirty=0 and produces no writeback.
  - The start in cycle 50 is ignored; only one done is produced.

Source files
------------

// File: rtl/ysyx_22051110_cache_flush_seq.sv
`default_nettype none
//==============================================================================
// Module  : ysyx_22051110_cache_flush_seq
// Purpose : D-cache maintenance sequencer. On a fence request it walks all 64
//           metadata sets and hands every valid+dirty line to the writeback
//           unit. It then either rewrites the entry as clean (clean mode) or
//           wipes the whole metadata RAM with a single flush pulse
//           (invalidate mode).
// Ports   : clock/reset    - clock, synchronous active-high reset
//           start/inv      - fence request and mode (sampled in IDLE only)
//           busy/done      - walk in progress / one-cycle completion pulse
//           meta_*  (out)  - metadata RAM enable, write select, address,
//                            write data and global flush
//           meta_*  (in)   - registered metadata read data (1-cycle latency)
//           wb_valid/ready - writeback request handshake (tag, index)
//           wb_done        - writeback unit finished writing the line
// Revision: 1.0 - initial release
//==============================================================================
module ysyx_22051110_cache_flush_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        inv,
   output logic        busy,
   output logic        done,
   output logic        meta_en,
   output logic        meta_wr,
   output logic [5:0]  meta_addr,
   output logic        meta_wvalid,
   output logic        meta_wdirty,
   output logic [22:0] meta_wtag,
   output logic        meta_flush,
   input  logic        meta_valid,
   input  logic        meta_dirty,
   input  logic [22:0] meta_tag,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [22:0] wb_tag,
   output logic [5:0]  wb_index,
   input  logic        wb_done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CHECK   = 3'd2,
      S_WB_REQ  = 3'd3,
      S_WB_WAIT = 3'd4,
      S_CLEAN   = 3'd5,
      S_FIN     = 3'd6
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [5:0]  idx;
   logic [5:0]  next_idx;
   logic        mode_inv;
   logic        next_mode_inv;
   logic [22:0] ltag;
   logic [22:0] next_ltag;
   logic        advance;
   logic        next_meta_en;
   logic        next_clean;
   logic        next_wb;

   // Next-state logic. Inputs only reach state registers here; every output
   // below is a flop loaded from the next-state values, so no input has a
   // combinational path to an output.
   always_comb begin
      next_state    = state;
      next_idx      = idx;
      next_mode_inv = mode_inv;
      next_ltag     = ltag;
      advance       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               next_mode_inv = inv;
               next_idx      = 6'd0;
               next_state    = S_READ;
            end
         end
         S_READ: begin
            next_state = S_CHECK;
         end
         S_CHECK: begin
            next_ltag = meta_tag;
            // Dirty-but-invalid entries are stale and must not be written back.
            if (meta_valid && meta_dirty) begin
               next_state = S_WB_REQ;
            end else begin
               advance = 1'b1;
            end
         end
         S_WB_REQ: begin
            // wb_valid is always high in this state, so ready alone completes
            // the handshake.
            if (wb_ready) begin
               next_state = S_WB_WAIT;
            end
         end
         S_WB_WAIT: begin
            if (wb_done) begin
               if (mode_inv) begin
                  advance = 1'b1;
               end else begin
                  next_state = S_CLEAN;
               end
            end
         end
         S_CLEAN: begin
            advance = 1'b1;
         end
         S_FIN: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      // Move to the next set, or finish after set 63 (idx never wraps).
      if (advance) begin
         if (idx == 6'd63) begin
            next_state = S_FIN;
         end else begin
            next_idx   = idx + 6'd1;
            next_state = S_READ;
         end
      end
   end

   assign next_meta_en = (next_state == S_READ) || (next_state == S_CLEAN);
   assign next_clean   = (next_state == S_CLEAN);
   assign next_wb      = (next_state == S_WB_REQ);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= 6'd0;
         mode_inv    <= 1'b0;
         ltag        <= 23'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         meta_en     <= 1'b0;
         meta_wr     <= 1'b0;
         meta_addr   <= 6'd0;
         meta_wvalid <= 1'b0;
         meta_wtag   <= 23'd0;
         meta_flush  <= 1'b0;
         wb_valid    <= 1'b0;
         wb_tag      <= 23'd0;
         wb_index    <= 6'd0;
      end else begin
         state       <= next_state;
         idx         <= next_idx;
         mode_inv    <= next_mode_inv;
         ltag        <= next_ltag;
         busy        <= (next_state != S_IDLE);
         done        <= (next_state == S_FIN);
         meta_flush  <= (next_state == S_FIN) && next_mode_inv;
         meta_en     <= next_meta_en;
         meta_wr     <= next_clean;
         meta_addr   <= next_meta_en ? next_idx : 6'd0;
         meta_wvalid <= next_clean;
         meta_wtag   <= next_clean ? next_ltag : 23'd0;
         // Tag and index are reloaded every WB_REQ cycle from registers that
         // do not change there, so they stay stable while ready is low.
         wb_valid    <= next_wb;
         wb_tag      <= next_wb ? next_ltag : 23'd0;
         wb_index    <= next_wb ? next_idx : 6'd0;
      end
   end

   // A clean rewrite always stores dirty=0; this bit is never set.
   assign meta_wdirty = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051110_cache_flush_seq.sv
`default_nettype none
//==============================================================================
// Module  : tb_ysyx_22051110_cache_flush_seq
// Purpose : Directed self-checking bench for the cache flush sequencer. A
//           behavioural metadata RAM (1-cycle registered read) feeds the DUT;
//           a simple writeback responder pulses wb_done a fixed number of
//           cycles after each accepted request. Cycle numbers count from the
//           edge that samples start (the first READ cycle is cycle 1).
// Revision: 1.0 - initial release
//==============================================================================
module tb_ysyx_22051110_cache_flush_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        inv = 1'b0;
   logic        busy, done, meta_en, meta_wr, meta_wvalid, meta_wdirty, meta_flush;
   logic [5:0]  meta_addr;
   logic [22:0] meta_wtag;
   logic        meta_valid = 1'b0;
   logic        meta_dirty = 1'b0;
   logic [22:0] meta_tag = 23'd0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [22:0] wb_tag;
   logic [5:0]  wb_index;
   logic        wb_done = 1'b0;

   int checks = 0;
   int fails = 0;

   ysyx_22051110_cache_flush_seq dut (
      .clock(clock), .reset(reset), .start(start), .inv(inv),
      .busy(busy), .done(done),
      .meta_en(meta_en), .meta_wr(meta_wr), .meta_addr(meta_addr),
      .meta_wvalid(meta_wvalid), .meta_wdirty(meta_wdirty), .meta_wtag(meta_wtag),
      .meta_flush(meta_flush),
      .meta_valid(meta_valid), .meta_dirty(meta_dirty), .meta_tag(meta_tag),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
      .wb_index(wb_index), .wb_done(wb_done)
   );

   always #5 clock = ~clock;

   logic [65:0] all_outs;
   assign all_outs = {busy, done, meta_en, meta_wr, meta_addr, meta_wvalid,
                      meta_wdirty, meta_wtag, meta_flush, wb_valid, wb_tag, wb_index};

   // Metadata RAM contents as set up by each test.
   logic        mv [64];
   logic        md [64];
   logic [22:0] mt [64];

   always @(posedge clock) begin
      if (meta_en && !meta_wr) begin
         meta_valid <= mv[meta_addr];
         meta_dirty <= md[meta_addr];
         meta_tag   <= mt[meta_addr];
      end
   end

   // Observations of one walk.
   int done_cnt, done_cyc, busy_fall, wbv_cycles, wr_n, flush_n, both_n, first_rd;
   int wb_n, cl_n, cl_cyc, wb_cnt;
   int wb_idx_log [4];
   int wb_cyc_log [4];
   logic [22:0] wb_tag_log [4];
   logic [5:0]  cl_addr;
   logic        cl_valid, cl_dirty;
   logic [22:0] cl_tag;

   task automatic clear_mem;
      for (int i = 0; i < 64; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
         mt[i] = 23'd0;
      end
   endtask

   // Runs one walk from a negedge; optionally pulses start (with inverted inv)
   // at cycle start_at while busy. Returns at a negedge, 8 cycles after busy drops.
   task automatic walk(input logic mode, input int delay, input int start_at);
      done_cnt = 0; done_cyc = -1; busy_fall = -1; wbv_cycles = 0; wr_n = 0;
      flush_n = 0; both_n = 0; first_rd = -1; wb_n = 0; cl_n = 0; cl_cyc = -1;
      wb_cnt = 0;
      start = 1'b1; inv = mode; wb_ready = 1'b1; wb_done = 1'b0;
      @(posedge clock);
      for (int c = 1; c <= 1500; c++) begin
         @(negedge clock);
         start = (c == start_at);
         inv = (c == start_at) ? ~mode : mode;
         wb_done = 1'b0;
         if (wb_cnt > 0) begin
            wb_cnt--;
            if (wb_cnt == 0) wb_done = 1'b1;
         end
         if (wb_valid && wb_ready) begin
            if (wb_n < 4) begin
               wb_idx_log[wb_n] = int'(wb_index);
               wb_tag_log[wb_n] = wb_tag;
               wb_cyc_log[wb_n] = c;
            end
            wb_n++;
            wb_cnt = delay;
         end
         if (wb_valid) wbv_cycles++;
         if (meta_wr) wr_n++;
         if (meta_en && meta_wr) begin
            if (cl_n == 0) begin
               cl_cyc = c; cl_addr = meta_addr; cl_valid = meta_wvalid;
               cl_dirty = meta_wdirty; cl_tag = meta_wtag;
            end
            cl_n++;
         end
         if (c == 1 && meta_en && !meta_wr) first_rd = int'(meta_addr);
         if (meta_flush) flush_n++;
         if (done) begin
            done_cnt++;
            done_cyc = c;
            if (meta_flush) both_n++;
         end
         if (!busy && busy_fall < 0) busy_fall = c;
         if (busy_fall >= 0 && c >= busy_fall + 8) break;
      end
      start = 1'b0; wb_done = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (all_outs !== 66'd0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_all_clean;
      clear_mem();
      walk(1'b0, 1, 0);
      checks++;
      if (first_rd !== 0) begin fails++; $display("FAIL clean_first_read: got %0d expected 0", first_rd); end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 129) begin
         fails++; $display("FAIL clean_done: got count %0d cycle %0d expected 1 at 129", done_cnt, done_cyc);
      end
      checks++;
      if (busy_fall !== 130) begin fails++; $display("FAIL clean_busy_fall: got %0d expected 130", busy_fall); end
      checks++;
      if (wbv_cycles !== 0 || wr_n !== 0 || flush_n !== 0) begin
         fails++; $display("FAIL clean_quiet: got wb_valid %0d meta_wr %0d flush %0d expected 0 0 0", wbv_cycles, wr_n, flush_n);
      end
   endtask

   task automatic test_single_dirty;
      clear_mem();
      mv[5] = 1'b1; md[5] = 1'b1; mt[5] = 23'h12345;
      walk(1'b0, 3, 0);
      checks++;
      if (wb_n !== 1 || wb_idx_log[0] !== 5 || wb_tag_log[0] !== 23'h12345 || wb_cyc_log[0] !== 13) begin
         fails++; $display("FAIL dirty5_request: got n %0d idx %0d tag %h cycle %0d expected 1 5 12345 13",
                           wb_n, wb_idx_log[0], wb_tag_log[0], wb_cyc_log[0]);
      end
      checks++;
      if (cl_n !== 1 || cl_cyc !== 17 || cl_addr !== 6'd5 || cl_valid !== 1'b1 || cl_dirty !== 1'b0 || cl_tag !== 23'h12345) begin
         fails++; $display("FAIL dirty5_clean_write: got n %0d cycle %0d addr %0d v %b d %b tag %h expected 1 17 5 1 0 12345",
                           cl_n, cl_cyc, cl_addr, cl_valid, cl_dirty, cl_tag);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 134 || flush_n !== 0) begin
         fails++; $display("FAIL dirty5_done: got count %0d cycle %0d flush %0d expected 1 134 0", done_cnt, done_cyc, flush_n);
      end
   endtask

   task automatic test_invalidate;
      clear_mem();
      mv[0] = 1'b1; md[0] = 1'b1; mt[0] = 23'h00ABC;
      mv[63] = 1'b1; md[63] = 1'b1; mt[63] = 23'h7FFFF;
      walk(1'b1, 1, 0);
      checks++;
      if (wb_n !== 2 || wb_idx_log[0] !== 0 || wb_idx_log[1] !== 63 || wb_tag_log[1] !== 23'h7FFFF) begin
         fails++; $display("FAIL inv_requests: got n %0d idx %0d,%0d tag1 %h expected 2 0,63 7ffff",
                           wb_n, wb_idx_log[0], wb_idx_log[1], wb_tag_log[1]);
      end
      checks++;
      if (cl_n !== 0 || wr_n !== 0) begin fails++; $display("FAIL inv_no_clean: got %0d writes expected 0", wr_n); end
      checks++;
      if (flush_n !== 1 || both_n !== 1 || done_cnt !== 1 || done_cyc !== 133) begin
         fails++; $display("FAIL inv_flush_done: got flush %0d together %0d done %0d at %0d expected 1 1 1 133",
                           flush_n, both_n, done_cnt, done_cyc);
      end
   endtask

   task automatic test_stall;
      int stable_ok;
      int d;
      stable_ok = 0; d = -1;
      clear_mem();
      mv[10] = 1'b1; md[10] = 1'b1; mt[10] = 23'h7ABCD;
      start = 1'b1; inv = 1'b0; wb_ready = 1'b0; wb_done = 1'b0;
      @(posedge clock);
      for (int c = 1; c <= 400; c++) begin
         @(negedge clock);
         start = 1'b0;
         wb_ready = (c >= 33);
         wb_done = (c == 25) || (c == 36);
         if (c >= 23 && c <= 33 && wb_valid === 1'b1 && wb_index === 6'd10 && wb_tag === 23'h7ABCD)
            stable_ok++;
         if (c == 34) begin
            checks++;
            if (wb_valid !== 1'b0) begin fails++; $display("FAIL stall_release: got wb_valid %b expected 0", wb_valid); end
         end
         if (c == 37) begin
            checks++;
            if (meta_en !== 1'b1 || meta_wr !== 1'b1 || meta_addr !== 6'd10 || meta_wtag !== 23'h7ABCD) begin
               fails++; $display("FAIL stall_clean: got en %b wr %b addr %0d tag %h expected 1 1 10 7abcd",
                                 meta_en, meta_wr, meta_addr, meta_wtag);
            end
         end
         if (done) begin d = c; break; end
      end
      wb_done = 1'b0; wb_ready = 1'b0;
      checks++;
      if (stable_ok !== 11) begin fails++; $display("FAIL stall_hold: got %0d stable cycles expected 11", stable_ok); end
      checks++;
      if (d !== 144) begin fails++; $display("FAIL stall_done: got cycle %0d expected 144", d); end
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      int bad;
      bad = 0;
      clear_mem();
      mv[10] = 1'b1; md[10] = 1'b1; mt[10] = 23'h55AA5;
      start = 1'b1; inv = 1'b1; wb_ready = 1'b1; wb_done = 1'b0;
      @(posedge clock);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || wb_valid !== 1'b0 || meta_en !== 1'b0) begin
         fails++; $display("FAIL mid_wb_wait: got busy %b wb_valid %b meta_en %b expected 1 0 0", busy, wb_valid, meta_en);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (all_outs !== 66'd0) begin fails++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs); end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wb_done = (k == 1);
         @(negedge clock);
         if (busy !== 1'b0 || done !== 1'b0 || meta_flush !== 1'b0) bad++;
      end
      wb_done = 1'b0;
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL mid_after_reset: got %0d active cycles expected 0", bad); end
      clear_mem();
      walk(1'b0, 1, 0);
      checks++;
      if (first_rd !== 0 || done_cyc !== 129 || wb_n !== 0) begin
         fails++; $display("FAIL mid_rewalk: got first %0d done %0d wb %0d expected 0 129 0", first_rd, done_cyc, wb_n);
      end
   endtask

   task automatic test_mixed;
      clear_mem();
      mv[3] = 1'b1; md[3] = 1'b0; mt[3] = 23'h00333;
      mv[20] = 1'b1; md[20] = 1'b1; mt[20] = 23'h2AAAA;
      mv[40] = 1'b0; md[40] = 1'b1; mt[40] = 23'h44444;
      walk(1'b0, 2, 50);
      checks++;
      if (wb_n !== 1 || wb_idx_log[0] !== 20 || wb_tag_log[0] !== 23'h2AAAA || wb_cyc_log[0] !== 43) begin
         fails++; $display("FAIL mixed_request: got n %0d idx %0d tag %h cycle %0d expected 1 20 2aaaa 43",
                           wb_n, wb_idx_log[0], wb_tag_log[0], wb_cyc_log[0]);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 133 || flush_n !== 0 || cl_n !== 1) begin
         fails++; $display("FAIL mixed_done: got done %0d at %0d flush %0d cleans %0d expected 1 133 0 1",
                           done_cnt, done_cyc, flush_n, cl_n);
      end
   endtask

   task automatic test_back_to_back;
      int d;
      d = -1;
      clear_mem();
      start = 1'b1; inv = 1'b0; wb_ready = 1'b1; wb_done = 1'b0;
      @(posedge clock);
      for (int c = 1; c <= 300; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (done) begin d = c; break; end
      end
      checks++;
      if (d !== 129) begin fails++; $display("FAIL b2b_first_done: got %0d expected 129", d); end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy %b expected 0", busy); end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || meta_en !== 1'b1 || meta_wr !== 1'b0 || meta_addr !== 6'd0) begin
         fails++; $display("FAIL b2b_restart: got busy %b en %b wr %b addr %0d expected 1 1 0 0", busy, meta_en, meta_wr, meta_addr);
      end
      d = -1;
      for (int c = 2; c <= 300; c++) begin
         @(negedge clock);
         if (done) begin d = c; break; end
      end
      checks++;
      if (d !== 129) begin fails++; $display("FAIL b2b_second_done: got %0d expected 129", d); end
      @(negedge clock);
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_all_clean();
      test_single_dirty();
      test_invalidate();
      test_stall();
      test_reset_mid();
      test_mixed();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
